// File: rtl/ula.sv
// Registered 64-bit add/subtract unit with zero/negative/carry/overflow flags.
// Optional signed/unsigned less-than flags are built when ULA_CMP_FLAGS_EN is defined.
module ula #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             lt,
  output logic             ltu
);

  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic             ovf_d;
  logic             s1_msb, s2_msb, res_msb;

  // Subtraction reuses the adder: s1 + ~s2 + 1, so carry-out means "no borrow".
  always_comb begin
    opb     = sub ? ~s2 : s2;
    sum     = {1'b0, s1} + {1'b0, opb} + {{WIDTH{1'b0}}, sub};
    s1_msb  = s1[WIDTH-1];
    s2_msb  = s2[WIDTH-1];
    res_msb = sum[WIDTH-1];
    if (sub) begin
      ovf_d = (s1_msb != s2_msb) && (res_msb != s1_msb);
    end else begin
      ovf_d = (s1_msb == s2_msb) && (res_msb != s1_msb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res      <= sum[WIDTH-1:0];
        zero     <= (sum[WIDTH-1:0] == '0);
        negative <= res_msb;
        carry    <= sum[WIDTH];
        overflow <= ovf_d;
      end
    end
  end

`ifdef ULA_CMP_FLAGS_EN
  // Compare flags only carry meaning for subtraction; additions register 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt  <= 1'b0;
      ltu <= 1'b0;
    end else if (in_valid) begin
      lt  <= sub & (res_msb ^ ovf_d);
      ltu <= sub & ~sum[WIDTH];
    end
  end
`else
  assign lt  = 1'b0;
  assign ltu = 1'b0;
`endif

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_ula;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] s1;
  logic [63:0] s2;
  logic        sub;
  logic        out_valid;
  logic [63:0] res;
  logic        zero, negative, carry, overflow, lt, ltu;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic        lt;
    logic        ltu;
  } exp_t;

  exp_t held;

  ula #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .s1        (s1),
    .s2        (s2),
    .sub       (sub),
    .out_valid (out_valid),
    .res       (res),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .lt        (lt),
    .ltu       (ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: true integer results, then judged against the 64-bit window.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sb);
    exp_t e;
    logic [64:0] usum;
    logic signed [65:0] ssum;
    if (sb) begin
      e.res   = a - b;
      e.carry = (a >= b);
      ssum    = 66'(signed'(a)) - 66'(signed'(b));
    end else begin
      usum    = {1'b0, a} + {1'b0, b};
      e.res   = usum[63:0];
      e.carry = (usum > 65'h0_FFFF_FFFF_FFFF_FFFF);
      ssum    = 66'(signed'(a)) + 66'(signed'(b));
    end
    e.ovf  = (ssum > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (ssum < -66'sh0_8000_0000_0000_0000);
    e.zero = (e.res == 64'd0);
    e.neg  = (signed'(e.res) < 0);
`ifdef ULA_CMP_FLAGS_EN
    e.lt  = sb && (signed'(a) < signed'(b));
    e.ltu = sb && (a < b);
`else
    e.lt  = 1'b0;
    e.ltu = 1'b0;
`endif
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e, input logic v);
    check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, v});
    check({tag, ".res"}, res, e.res);
    check({tag, ".zero"}, {63'd0, zero}, {63'd0, e.zero});
    check({tag, ".neg"}, {63'd0, negative}, {63'd0, e.neg});
    check({tag, ".carry"}, {63'd0, carry}, {63'd0, e.carry});
    check({tag, ".ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
    check({tag, ".lt"}, {63'd0, lt}, {63'd0, e.lt});
    check({tag, ".ltu"}, {63'd0, ltu}, {63'd0, e.ltu});
  endtask

  // One valid operation: drive on the falling edge, sample 1 ns after the capture edge.
  task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sb);
    @(negedge clk);
    in_valid = 1'b1;
    s1       = a;
    s2       = b;
    sub      = sb;
    @(posedge clk);
    #1;
    held = model(a, b, sb);
    check_all(tag, held, 1'b1);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    s1       = {$urandom, $urandom};
    s2       = {$urandom, $urandom};
    sub      = 1'($urandom);
    @(posedge clk);
    #1;
    check_all(tag, held, 1'b0);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      s1       = {$urandom, $urandom};
      s2       = {$urandom, $urandom};
      sub      = 1'($urandom);
      @(posedge clk);
      #1;
    end
    held = '{res: 64'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0, lt: 1'b0, ltu: 1'b0};
    check_all(tag, held, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  logic [63:0] corners [8];

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    s1       = '0;
    s2       = '0;
    sub      = 1'b0;
    corners  = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd30, 64'd29};

    do_reset("reset", 2);

    apply("sub_1_m45", 64'd1, -64'd45, 1'b1);
    check("sub_1_m45.res46", res, 64'd46);
    apply("sub_m10000_m4197", -64'd10000, -64'd4197, 1'b1);
    check("sub_m10000_m4197.res", res, -64'd5803);
    apply("sub_10000_5461", 64'd10000, 64'd5461, 1'b1);
    check("sub_10000_5461.res", res, 64'd4539);
    apply("ovf_min_minus_big", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFF8, 1'b1);
    check("ovf_min_minus_big.res8", res, 64'd8);
    check("ovf_min_minus_big.ovf1", {63'd0, overflow}, 64'd1);
    apply("ovf_min_minus_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    check("ovf_min_minus_max.res1", res, 64'd1);
    apply("uns_small_minus_ones", 64'd12873481, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("uns_small_minus_ones.res", res, 64'd12873482);
    check("uns_small_minus_ones.carry0", {63'd0, carry}, 64'd0);
    apply("uns_swapped", 64'hFFFF_FFFF_FFFF_FFFF, 64'd12873481, 1'b1);
    check("uns_swapped.carry1", {63'd0, carry}, 64'd1);
    apply("sub_29_30", 64'd29, 64'd30, 1'b1);
    check("sub_29_30.resm1", res, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("eq_m2", -64'd2, -64'd2, 1'b1);
    apply("eq_4", 64'd4, 64'd4, 1'b1);
    apply("eq_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    check("eq_ones.zero1", {63'd0, zero}, 64'd1);
    apply("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("add_wrap.zero1", {63'd0, zero}, 64'd1);
    check("add_wrap.carry1", {63'd0, carry}, 64'd1);

    // Back-to-back valid operations, then hold with out_valid low.
    apply("pipe0", 64'd100, 64'd7, 1'b0);
    apply("pipe1", 64'd100, 64'd7, 1'b1);
    apply("pipe2", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    idle("hold0");
    idle("hold1");

    // Reset mid-stream discards the pending operation.
    apply("pre_reset", 64'd5, 64'd9, 1'b1);
    do_reset("mid_reset", 1);
    idle("post_reset_idle");

    for (int i = 0; i < 300; i++) begin
      logic [63:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) b = a;
      if ($urandom_range(0, 7) == 0) idle("rand_idle");
      else apply("rand", a, b, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
